// File: rtl/bbpfd_acc_pkg.sv
// Shared types for the clocked bang-bang phase detector.
// FSM states and signed two-bit decision codes.
package bbpfd_acc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GEN = 2'd1,
      WAIT_REF = 2'd2
   } state_t;

   localparam logic [1:0] DEC_TIE = 2'b00;
   localparam logic [1:0] DEC_POS = 2'b01;
   localparam logic [1:0] DEC_NEG = 2'b11;

endpackage

// File: rtl/bbpfd_acc_edge_sync.sv
// Multi-flop synchroniser for an asynchronous clock input.
// Adds a history flop and a registered rising-edge flag.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;

   // shift the input through the synchroniser, flag a 0->1 transition
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         hist <= 1'b0;
         rise <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         hist <= sync[SYNC_STAGES-1];
         rise <= sync[SYNC_STAGES-1] & ~hist;
      end
   end

endmodule

// File: rtl/bbpfd_acc.sv
// Clocked bang-bang phase detector with slip detection and
// a saturating accumulator of signed decisions.
module bbpfd_acc
   import bbpfd_acc_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WIN_MAX     = 255,
   parameter int TMR_W       = 8,
   parameter int ACC_CYCLES  = 4,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ref_in,
   input  logic             gen_in,
   output logic             pd_out,
   output logic             dec_valid,
   output logic [1:0]       dec,
   output logic             slip,
   output logic [ERR_W-1:0] err,
   output logic             err_valid
);

   localparam int CNT_W = (ACC_CYCLES < 2) ? 1 : $clog2(ACC_CYCLES + 1);
   localparam int LIM   = (1 << (ERR_W - 1)) - 1;
   localparam logic signed [ERR_W:0] LIM_P = (ERR_W+1)'(LIM);
   localparam logic signed [ERR_W:0] LIM_N = -LIM_P;
   localparam logic [TMR_W-1:0] WIN_T = TMR_W'(WIN_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);

   logic             ref_e;
   logic             gen_e;
   state_t           state;
   state_t           state_nx;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_nx;
   logic             d_fire;
   logic [1:0]       d_code;
   logic             d_slip;

   logic signed [ERR_W-1:0] acc;
   logic signed [ERR_W:0]   sum_full;
   logic signed [ERR_W-1:0] sum;
   logic [CNT_W-1:0]        dcnt;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (ref_in),
      .rise (ref_e)
   );

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_gen_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (gen_in),
      .rise (gen_e)
   );

   // FSM state and window timer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
      end
   end

   // pair edges, detect slips and timeouts, pick one decision per cycle
   always_comb begin
      state_nx = state;
      timer_nx = timer;
      d_fire   = 1'b0;
      d_code   = DEC_TIE;
      d_slip   = 1'b0;
      if (!en) begin
         state_nx = IDLE;
         timer_nx = '0;
      end else begin
         unique case (state)
            IDLE: begin
               timer_nx = '0;
               if (ref_e && gen_e) begin
                  d_fire = 1'b1;
               end else if (ref_e) begin
                  state_nx = WAIT_GEN;
               end else if (gen_e) begin
                  state_nx = WAIT_REF;
               end
            end
            WAIT_GEN: begin
               if (ref_e) begin
                  d_fire   = 1'b1;
                  d_code   = DEC_POS;
                  d_slip   = 1'b1;
                  timer_nx = '0;
                  if (gen_e) state_nx = IDLE;
               end else if (gen_e) begin
                  d_fire   = 1'b1;
                  d_code   = DEC_POS;
                  timer_nx = '0;
                  state_nx = IDLE;
               end else if (timer == WIN_T) begin
                  d_fire   = 1'b1;
                  d_code   = DEC_POS;
                  d_slip   = 1'b1;
                  timer_nx = '0;
                  state_nx = IDLE;
               end else begin
                  timer_nx = timer + TMR_W'(1);
               end
            end
            WAIT_REF: begin
               if (gen_e) begin
                  d_fire   = 1'b1;
                  d_code   = DEC_NEG;
                  d_slip   = 1'b1;
                  timer_nx = '0;
                  if (ref_e) state_nx = IDLE;
               end else if (ref_e) begin
                  d_fire   = 1'b1;
                  d_code   = DEC_NEG;
                  timer_nx = '0;
                  state_nx = IDLE;
               end else if (timer == WIN_T) begin
                  d_fire   = 1'b1;
                  d_code   = DEC_NEG;
                  d_slip   = 1'b1;
                  timer_nx = '0;
                  state_nx = IDLE;
               end else begin
                  timer_nx = timer + TMR_W'(1);
               end
            end
            default: begin
               state_nx = IDLE;
               timer_nx = '0;
            end
         endcase
      end
   end

   // register the decision and the level bang-bang output
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_valid <= 1'b0;
         dec       <= DEC_TIE;
         slip      <= 1'b0;
         pd_out    <= 1'b0;
      end else begin
         dec_valid <= d_fire;
         slip      <= d_fire & d_slip;
         if (d_fire) begin
            dec <= d_code;
            if (d_code == DEC_POS) pd_out <= 1'b1;
            else if (d_code == DEC_NEG) pd_out <= 1'b0;
         end
      end
   end

   // saturating add of the registered decision onto the running sum
   always_comb begin
      sum_full = $signed({acc[ERR_W-1], acc})
               + $signed({{(ERR_W-1){dec[1]}}, dec});
      if (sum_full > LIM_P) sum = LIM_P[ERR_W-1:0];
      else if (sum_full < LIM_N) sum = LIM_N[ERR_W-1:0];
      else sum = sum_full[ERR_W-1:0];
   end

   // accumulate ACC_CYCLES decisions, then publish and restart
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         dcnt      <= '0;
         err       <= '0;
         err_valid <= 1'b0;
      end else begin
         err_valid <= 1'b0;
         if (dec_valid) begin
            if (dcnt == CNT_LAST) begin
               err       <= sum;
               err_valid <= 1'b1;
               acc       <= '0;
               dcnt      <= '0;
            end else begin
               acc  <= sum;
               dcnt <= dcnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bbpfd_acc.sv
// Directed bench for bbpfd_acc: table of edge pairs plus
// hand sequences for timeout, slip, saturation, reset, enable.
module tb_bbpfd_acc;

   logic clk = 1'b0;
   logic rst;
   logic en_a;
   logic en_b;
   logic ref_in;
   logic gen_in;

   logic       pd_a, dv_a, slip_a, ev_a;
   logic [1:0] dec_a;
   logic [7:0] err_a;
   logic       pd_b, dv_b, slip_b, ev_b;
   logic [1:0] dec_b;
   logic [2:0] err_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int dec;
      int slip;
      int pd;
      int cyc;
   } ev_t;

   typedef struct {
      int rd;
      int gd;
      int dec;
      int slip;
      int pd;
   } vec_t;

   ev_t qa[$];
   ev_t qb[$];
   int  qea[$];
   int  qeb[$];

   bbpfd_acc #(
      .SYNC_STAGES(2), .WIN_MAX(20), .TMR_W(8),
      .ACC_CYCLES(4), .ERR_W(8)
   ) u_a (
      .clk(clk), .rst(rst), .en(en_a),
      .ref_in(ref_in), .gen_in(gen_in),
      .pd_out(pd_a), .dec_valid(dv_a), .dec(dec_a),
      .slip(slip_a), .err(err_a), .err_valid(ev_a)
   );

   bbpfd_acc #(
      .ACC_CYCLES(8), .ERR_W(3)
   ) u_b (
      .clk(clk), .rst(rst), .en(en_b),
      .ref_in(ref_in), .gen_in(gen_in),
      .pd_out(pd_b), .dec_valid(dv_b), .dec(dec_b),
      .slip(slip_b), .err(err_b), .err_valid(ev_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      ev_t e;
      if (dv_a) begin
         e.dec  = int'($signed(dec_a));
         e.slip = int'(slip_a);
         e.pd   = int'(pd_a);
         e.cyc  = cyc;
         qa.push_back(e);
      end
      if (dv_b) begin
         e.dec  = int'($signed(dec_b));
         e.slip = int'(slip_b);
         e.pd   = int'(pd_b);
         e.cyc  = cyc;
         qb.push_back(e);
      end
      if (ev_a) qea.push_back(int'($signed(err_a)));
      if (ev_b) qeb.push_back(int'($signed(err_b)));
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pair(input int rd, input int gd);
      int last;
      last = (rd > gd) ? rd : gd;
      for (int t = 0; t <= last; t++) begin
         ref_in = (t >= rd);
         gen_in = (t >= gd);
         tick();
      end
      repeat (2) tick();
      ref_in = 1'b0;
      gen_in = 1'b0;
      repeat (8) tick();
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      ref_in = 1'b0;
      gen_in = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      tick();
      qa.delete();
      qb.delete();
      qea.delete();
      qeb.delete();
   endtask

   vec_t vt[12];
   int   grp_err[3];
   int   c0;

   initial begin
      rst    = 1'b1;
      en_a   = 1'b0;
      en_b   = 1'b0;
      ref_in = 1'b0;
      gen_in = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_pd", int'(pd_a), 0);
      chk("rst_dv", int'(dv_a), 0);
      chk("rst_dec", int'(dec_a), 0);
      chk("rst_slip", int'(slip_a), 0);
      chk("rst_err", int'(err_a), 0);
      chk("rst_ev", int'(ev_a), 0);
      chk("rst_err_b", int'(err_b), 0);
      do_reset();

      for (int i = 0; i < 4; i++) begin
         vt[i]   = '{rd: 0, gd: 10, dec: 1, slip: 0, pd: 1};
         vt[i+4] = '{rd: 0, gd: 0, dec: 0, slip: 0, pd: 1};
         vt[i+8] = '{rd: 5, gd: 0, dec: -1, slip: 0, pd: 0};
      end
      grp_err[0] = 4;
      grp_err[1] = 0;
      grp_err[2] = -4;

      en_a = 1'b1;
      for (int i = 0; i < 12; i++) begin
         qa.delete();
         pair(vt[i].rd, vt[i].gd);
         chk($sformatf("v%0d_count", i), qa.size(), 1);
         if (qa.size() > 0) begin
            chk($sformatf("v%0d_dec", i), qa[0].dec, vt[i].dec);
            chk($sformatf("v%0d_slip", i), qa[0].slip, vt[i].slip);
            chk($sformatf("v%0d_pd", i), qa[0].pd, vt[i].pd);
         end
         if ((i % 4) == 3) begin
            chk($sformatf("g%0d_errv", i / 4), qea.size(), 1);
            if (qea.size() > 0)
               chk($sformatf("g%0d_err", i / 4), qea[0], grp_err[i / 4]);
            chk($sformatf("g%0d_hold", i / 4),
                int'($signed(err_a)), grp_err[i / 4]);
            qea.delete();
         end
      end

      en_a = 1'b0;
      en_b = 1'b1;
      qa.delete();
      for (int i = 0; i < 8; i++) pair(0, 3);
      chk("sat_pos_errv", qeb.size(), 1);
      if (qeb.size() > 0) chk("sat_pos_err", qeb[0], 3);
      chk("sat_pos_pd", int'(pd_b), 1);
      chk("sat_pos_dv", qb.size(), 8);
      qeb.delete();
      for (int i = 0; i < 8; i++) pair(3, 0);
      chk("sat_neg_errv", qeb.size(), 1);
      if (qeb.size() > 0) chk("sat_neg_err", qeb[0], -3);
      chk("sat_neg_pd", int'(pd_b), 0);
      chk("dis_dv", qa.size(), 0);
      chk("dis_errv", qea.size(), 0);
      chk("dis_err_hold", int'($signed(err_a)), -4);
      en_b = 1'b0;

      do_reset();
      en_a = 1'b1;
      tick();
      ref_in = 1'b1;
      c0 = cyc;
      repeat (35) tick();
      ref_in = 1'b0;
      repeat (5) tick();
      chk("tmo_count", qa.size(), 1);
      if (qa.size() > 0) begin
         chk("tmo_cyc", qa[0].cyc - c0, 25);
         chk("tmo_dec", qa[0].dec, 1);
         chk("tmo_slip", qa[0].slip, 1);
         chk("tmo_pd", qa[0].pd, 1);
      end

      qa.delete();
      ref_in = 1'b1;
      c0 = cyc;
      repeat (5) tick();
      ref_in = 1'b0;
      repeat (5) tick();
      ref_in = 1'b1;
      repeat (40) tick();
      ref_in = 1'b0;
      repeat (5) tick();
      chk("reslip_count", qa.size(), 2);
      if (qa.size() > 1) begin
         chk("reslip0_cyc", qa[0].cyc - c0, 14);
         chk("reslip0_slip", qa[0].slip, 1);
         chk("reslip0_dec", qa[0].dec, 1);
         chk("reslip1_cyc", qa[1].cyc - c0, 35);
         chk("reslip1_slip", qa[1].slip, 1);
      end

      qa.delete();
      ref_in = 1'b1;
      repeat (8) tick();
      rst    = 1'b1;
      ref_in = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_pd", int'(pd_a), 0);
      chk("mid_rst_dv", int'(dv_a), 0);
      chk("mid_rst_err", int'(err_a), 0);
      repeat (40) tick();
      chk("mid_rst_none", qa.size(), 0);
      chk("mid_rst_slip", int'(slip_a), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
